bram_fib_seq: RTL and testbench

- Parameterised dual-port BRAM sequencer that fills a BRAM region with the Fibonacci sequence through port A, then reads it back through port B and checks it.
- Sits between the top-level control (start/mode) and the dual-port block RAM. Generalises the fixed-step BRAM driver with configurable width, depth, base address and read latency.
- Adds a start/busy/done handshake, write/verify modes and error reporting.

---
 rtl/bram_fib_seq_if.sv | 33 +++
 rtl/bram_fib_seq.sv | 193 +++++++++++++++++++
 tb/tb_bram_fib_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fib_seq_if.sv
// Control and dual-port BRAM signal bundle for the Fibonacci fill/verify sequencer.
// The master side is the top-level control plus the RAM; the slave side is the sequencer.
interface bram_fib_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 8
);
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data_a;
    logic [ADDR_W-1:0] addr_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_b;
    logic              we_b;
    logic [DATA_W-1:0] q_b;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        output start, mode, q_b,
        input  data_a, addr_a, we_a, addr_b, we_b,
        input  busy, done, pass, err_count, first_err_addr
    );

    modport slave (
        input  start, mode, q_b,
        output data_a, addr_a, we_a, addr_b, we_b,
        output busy, done, pass, err_count, first_err_addr
    );
endinterface

// File: rtl/bram_fib_seq.sv
// Fills a BRAM region with the Fibonacci sequence through port A, then reads it
// back through port B and counts mismatches against a regenerated sequence.
module bram_fib_seq #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned N_WORDS   = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned CNT_W     = 8
) (
    input logic           clk,
    input logic           reset,
    bram_fib_seq_if.slave bus
);

    localparam int unsigned        IDX_W      = ADDR_W + 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_WORDS - 1);
    localparam logic [IDX_W-1:0]   LAST_DRAIN = IDX_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [DATA_W-1:0]                 fa_q, fa_d, fb_q, fb_d;
    logic [1:0]                        mode_q, mode_d;
    logic                              we_a_q, we_a_d;
    logic [ADDR_W-1:0]                 addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_W-1:0]                 data_a_q, data_a_d;
    logic                              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                              seen_q, seen_d;
    logic [CNT_W-1:0]                  err_q, err_d;
    logic [ADDR_W-1:0]                 ferr_q, ferr_d;
    // Expected-value pipeline: stage 0 lines up with addr_b, stage READ_LAT with q_b.
    logic [READ_LAT:0]                 pv_q, pv_d;
    logic [READ_LAT:0][DATA_W-1:0]     pe_q, pe_d;
    logic [READ_LAT:0][ADDR_W-1:0]     pa_q, pa_d;
    logic                              push_v;
    logic [DATA_W-1:0]                 push_e;
    logic [ADDR_W-1:0]                 push_a;
    logic [ADDR_W-1:0]                 cur_addr;

    assign cur_addr = BASE + ADDR_W'(idx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            mode_q   <= '0;
            we_a_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            seen_q   <= 1'b0;
            err_q    <= '0;
            ferr_q   <= '0;
            pv_q     <= '0;
            pe_q     <= '0;
            pa_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            mode_q   <= mode_d;
            we_a_q   <= we_a_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            seen_q   <= seen_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            pv_q     <= pv_d;
            pe_q     <= pe_d;
            pa_q     <= pa_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        mode_d   = mode_q;
        we_a_d   = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = data_a_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = pass_q;
        seen_d   = seen_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        push_v   = 1'b0;
        push_e   = fa_q;
        push_a   = cur_addr;

        // Readback compare at the tail of the pipeline.
        if (pv_q[READ_LAT] && (bus.q_b != pe_q[READ_LAT])) begin
            if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
            if (!seen_q) begin
                seen_d = 1'b1;
                ferr_d = pa_q[READ_LAT];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    err_d  = '0;
                    ferr_d = '0;
                    pass_d = 1'b0;
                    seen_d = 1'b0;
                    idx_d  = '0;
                    fa_d   = '0;
                    fb_d   = DATA_W'(1);
                    mode_d = bus.mode;
                    if (bus.mode[0])      state_d = S_WRITE;
                    else if (bus.mode[1]) state_d = S_READ;
                    else                  state_d = S_DONE;
                end
            end
            S_WRITE: begin
                busy_d   = 1'b1;
                we_a_d   = 1'b1;
                addr_a_d = cur_addr;
                data_a_d = fa_q;
                fa_d     = fb_q;
                fb_d     = fa_q + fb_q;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    fa_d    = '0;
                    fb_d    = DATA_W'(1);
                    state_d = mode_q[1] ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                busy_d   = 1'b1;
                addr_b_d = cur_addr;
                push_v   = 1'b1;
                fa_d     = fb_q;
                fb_d     = fa_q + fb_q;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_d = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == LAST_DRAIN) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = ~seen_d;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pv_d = {pv_q[READ_LAT-1:0], push_v};
        pe_d = {pe_q[READ_LAT-1:0], push_e};
        pa_d = {pa_q[READ_LAT-1:0], push_a};
    end

    assign bus.data_a         = data_a_q;
    assign bus.addr_a         = addr_a_q;
    assign bus.we_a           = we_a_q;
    assign bus.addr_b         = addr_b_q;
    assign bus.we_b           = 1'b0;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_err_addr = ferr_q;

endmodule

// File: tb/tb_bram_fib_seq.sv
// Directed bench: four sequencer instances (different width/base/latency) each
// paired with a behavioural dual-port BRAM, driven from one linear sequence.
module tb_bram_fib_seq;

    logic       clk;
    logic       reset;
    logic [3:0] start_v;
    logic [1:0] mode_r;
    logic       corrupt;
    int         sel_r;
    int         n_asserts;
    int         n_fail;

    int fib_tab [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

    bram_fib_seq_if #(.DATA_W(16), .ADDR_W(10), .CNT_W(8)) if0 ();
    bram_fib_seq_if #(.DATA_W(16), .ADDR_W(10), .CNT_W(8)) if1 ();
    bram_fib_seq_if #(.DATA_W(8),  .ADDR_W(10), .CNT_W(8)) if2 ();
    bram_fib_seq_if #(.DATA_W(16), .ADDR_W(10), .CNT_W(8)) if3 ();

    bram_fib_seq #(.DATA_W(16), .ADDR_W(10), .N_WORDS(8), .BASE_ADDR(4), .READ_LAT(1), .CNT_W(8))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    bram_fib_seq #(.DATA_W(16), .ADDR_W(10), .N_WORDS(8), .BASE_ADDR(4), .READ_LAT(2), .CNT_W(8))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    bram_fib_seq #(.DATA_W(8), .ADDR_W(10), .N_WORDS(16), .BASE_ADDR(0), .READ_LAT(1), .CNT_W(8))
        u2 (.clk(clk), .reset(reset), .bus(if2));
    bram_fib_seq #(.DATA_W(16), .ADDR_W(10), .N_WORDS(8), .BASE_ADDR(1020), .READ_LAT(1), .CNT_W(8))
        u3 (.clk(clk), .reset(reset), .bus(if3));

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if3.start = start_v[3];
    assign if0.mode  = mode_r;
    assign if1.mode  = mode_r;
    assign if2.mode  = mode_r;
    assign if3.mode  = mode_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAMs; instance 0 can corrupt reads of addresses 7 and 9.
    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];
    logic [7:0]  mem2 [1024];
    logic [15:0] mem3 [1024];
    logic [15:0] rd0, rd1a, rd1b, rd3;
    logic [7:0]  rd2;

    always @(posedge clk) begin
        if (if0.we_a) mem0[if0.addr_a] <= if0.data_a;
        if (corrupt && if0.addr_b == 10'd7)      rd0 <= 16'h0000;
        else if (corrupt && if0.addr_b == 10'd9) rd0 <= mem0[if0.addr_b] ^ 16'h0001;
        else                                     rd0 <= mem0[if0.addr_b];
        if (if1.we_a) mem1[if1.addr_a] <= if1.data_a;
        rd1a <= mem1[if1.addr_b];
        rd1b <= rd1a;
        if (if2.we_a) mem2[if2.addr_a] <= if2.data_a;
        rd2 <= mem2[if2.addr_b];
        if (if3.we_a) mem3[if3.addr_a] <= if3.data_a;
        rd3 <= mem3[if3.addr_b];
    end

    assign if0.q_b = rd0;
    assign if1.q_b = rd1b;
    assign if2.q_b = rd2;
    assign if3.q_b = rd3;

    logic [31:0] m_we, m_busy, m_done, m_pass, m_err, m_ferr, m_addr_a, m_addr_b, m_data_a, m_we_b;

    always_comb begin
        m_we = '0; m_busy = '0; m_done = '0; m_pass = '0; m_err = '0;
        m_ferr = '0; m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_we_b = '0;
        case (sel_r)
            0: begin
                m_we = 32'(if0.we_a); m_busy = 32'(if0.busy); m_done = 32'(if0.done);
                m_pass = 32'(if0.pass); m_err = 32'(if0.err_count); m_ferr = 32'(if0.first_err_addr);
                m_addr_a = 32'(if0.addr_a); m_addr_b = 32'(if0.addr_b); m_data_a = 32'(if0.data_a);
                m_we_b = 32'(if0.we_b);
            end
            1: begin
                m_we = 32'(if1.we_a); m_busy = 32'(if1.busy); m_done = 32'(if1.done);
                m_pass = 32'(if1.pass); m_err = 32'(if1.err_count); m_ferr = 32'(if1.first_err_addr);
                m_addr_a = 32'(if1.addr_a); m_addr_b = 32'(if1.addr_b); m_data_a = 32'(if1.data_a);
                m_we_b = 32'(if1.we_b);
            end
            2: begin
                m_we = 32'(if2.we_a); m_busy = 32'(if2.busy); m_done = 32'(if2.done);
                m_pass = 32'(if2.pass); m_err = 32'(if2.err_count); m_ferr = 32'(if2.first_err_addr);
                m_addr_a = 32'(if2.addr_a); m_addr_b = 32'(if2.addr_b); m_data_a = 32'(if2.data_a);
                m_we_b = 32'(if2.we_b);
            end
            default: begin
                m_we = 32'(if3.we_a); m_busy = 32'(if3.busy); m_done = 32'(if3.done);
                m_pass = 32'(if3.pass); m_err = 32'(if3.err_count); m_ferr = 32'(if3.first_err_addr);
                m_addr_a = 32'(if3.addr_a); m_addr_b = 32'(if3.addr_b); m_data_a = 32'(if3.data_a);
                m_we_b = 32'(if3.we_b);
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One run: start rises just after an edge; k counts edges from then on.
    task automatic run(input int sel, input logic [1:0] md, input int n, input int base,
                       input int dw, input int poke_at, input int rst_at,
                       output int we_cnt, output int done_cnt, output int done_cyc);
        int          rcnt;
        int          rd_first;
        int          budget;
        logic [31:0] mask;
        mask     = (32'd1 << dw) - 32'd1;
        we_cnt   = 0;
        done_cnt = 0;
        done_cyc = 0;
        rcnt     = 0;
        rd_first = (md[0] ? n : 0) + 2;
        budget   = 2 * n + 12;
        sel_r    = sel;
        mode_r   = md;
        @(posedge clk); #1;
        start_v[sel] = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (k == 1) start_v[sel] = 1'b0;
            if (m_we[0]) begin
                if (we_cnt < 16) begin
                    chk("addr_a", m_addr_a, 32'((base + we_cnt) % 1024));
                    chk("data_a", m_data_a, 32'(fib_tab[we_cnt]) & mask);
                end
                we_cnt++;
            end
            if (md[1] && rst_at == 0 && k >= rd_first && k < rd_first + n) begin
                chk("addr_b", m_addr_b, 32'((base + rcnt) % 1024));
                rcnt++;
            end
            if (m_done[0]) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k == poke_at) start_v[sel] = 1'b1;
            if (k == poke_at + 1) start_v[sel] = 1'b0;
            if (k == rst_at) begin
                #1 reset = 1'b0;
                #1;
                chk("we_a_async_rst", m_we, 0);
                chk("busy_async_rst", m_busy, 0);
            end
            if (rst_at != 0 && k == rst_at + 1) reset = 1'b1;
        end
    endtask

    int we_cnt, done_cnt, done_cyc;

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        start_v   = '0;
        mode_r    = 2'b00;
        corrupt   = 1'b0;
        sel_r     = 0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        chk("rst_we_a", m_we, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_pass", m_pass, 0);
        chk("rst_err_count", m_err, 0);
        chk("rst_first_err", m_ferr, 0);
        chk("rst_addr_a", m_addr_a, 0);
        chk("rst_addr_b", m_addr_b, 0);
        chk("rst_data_a", m_data_a, 0);
        chk("rst_we_b", m_we_b, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Write only: 8 words at 4..11, done N+2 edges after start.
        run(0, 2'b01, 8, 4, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("w_we_cnt", 32'(we_cnt), 8);
        chk("w_done_cnt", 32'(done_cnt), 1);
        chk("w_done_cyc", 32'(done_cyc), 10);
        chk("w_pass", m_pass, 1);
        chk("w_err", m_err, 0);
        chk("w_ferr", m_ferr, 0);

        // Write + verify, READ_LAT=1: done at 2*8+1+2.
        run(0, 2'b11, 8, 4, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("wv_we_cnt", 32'(we_cnt), 8);
        chk("wv_done_cnt", 32'(done_cnt), 1);
        chk("wv_done_cyc", 32'(done_cyc), 19);
        chk("wv_pass", m_pass, 1);
        chk("wv_err", m_err, 0);

        // Corrupted readback at addresses 7 and 9.
        corrupt = 1'b1;
        run(0, 2'b11, 8, 4, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        corrupt = 1'b0;
        chk("bad_done_cyc", 32'(done_cyc), 19);
        chk("bad_err", m_err, 2);
        chk("bad_ferr", m_ferr, 7);
        chk("bad_pass", m_pass, 0);

        // Start pulsed mid-READ is ignored.
        run(0, 2'b11, 8, 4, 16, 12, 0, we_cnt, done_cnt, done_cyc);
        chk("poke_done_cnt", 32'(done_cnt), 1);
        chk("poke_done_cyc", 32'(done_cyc), 19);
        chk("poke_pass", m_pass, 1);
        chk("poke_err", m_err, 0);

        // Reset while WRITE drives index 3: run aborts, no done.
        run(0, 2'b11, 8, 4, 16, 0, 5, we_cnt, done_cnt, done_cyc);
        chk("abort_we_cnt", 32'(we_cnt), 4);
        chk("abort_done_cnt", 32'(done_cnt), 0);
        chk("abort_pass", m_pass, 0);

        run(0, 2'b11, 8, 4, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("rerun_we_cnt", 32'(we_cnt), 8);
        chk("rerun_done_cyc", 32'(done_cyc), 19);
        chk("rerun_pass", m_pass, 1);

        // No phases enabled.
        run(0, 2'b00, 8, 4, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("m00_we_cnt", 32'(we_cnt), 0);
        chk("m00_done_cnt", 32'(done_cnt), 1);
        chk("m00_done_cyc", 32'(done_cyc), 2);
        chk("m00_pass", m_pass, 1);
        chk("m00_err", m_err, 0);

        // READ_LAT=2: one cycle later.
        run(1, 2'b11, 8, 4, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("lat2_done_cnt", 32'(done_cnt), 1);
        chk("lat2_done_cyc", 32'(done_cyc), 20);
        chk("lat2_pass", m_pass, 1);
        chk("lat2_err", m_err, 0);

        // 8-bit data: values wrap modulo 256.
        run(2, 2'b11, 16, 0, 8, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("w8_we_cnt", 32'(we_cnt), 16);
        chk("w8_done_cyc", 32'(done_cyc), 35);
        chk("w8_pass", m_pass, 1);
        chk("w8_mem13", 32'(mem2[13]), 233);
        chk("w8_mem14", 32'(mem2[14]), 121);
        chk("w8_mem15", 32'(mem2[15]), 98);

        // Base 1020: addresses wrap 1020..1023, 0..3.
        run(3, 2'b11, 8, 1020, 16, 0, 0, we_cnt, done_cnt, done_cyc);
        chk("wrap_we_cnt", 32'(we_cnt), 8);
        chk("wrap_done_cyc", 32'(done_cyc), 19);
        chk("wrap_pass", m_pass, 1);
        chk("wrap_mem1023", 32'(mem3[1023]), 2);
        chk("wrap_mem0", 32'(mem3[0]), 3);
        chk("wrap_mem3", 32'(mem3[3]), 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
